hex_display_scan: RTL and testbench



---
 rtl/hex_display_scan_if.sv | 24 ++
 rtl/hex_display_scan.sv | 153 +++++++++++++++
 tb/tb_hex_display_scan.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/hex_display_scan_if.sv
// Pin bundle between the status datapath and the seven-segment scanner.
// master drives value/dp/digit_en/load; slave returns busy and the pin outputs.
interface hex_display_scan_if #(
    parameter int NUM_DIGITS = 4
);
    logic [4*NUM_DIGITS-1:0] value;
    logic [NUM_DIGITS-1:0]   dp;
    logic [NUM_DIGITS-1:0]   digit_en;
    logic                    load;
    logic                    busy;
    logic                    frame_tick;
    logic [NUM_DIGITS-1:0]   anode;
    logic [7:0]              cathode;

    modport master (
        output value, dp, digit_en, load,
        input  busy, frame_tick, anode, cathode
    );

    modport slave (
        input  value, dp, digit_en, load,
        output busy, frame_tick, anode, cathode
    );
endinterface

// File: rtl/hex_display_scan.sv
// Time-multiplexed hex driver for common-anode seven-segment displays.
// Optional LEADING_ZERO_BLANK_EN darkens enabled leading zero digits.
module hex_display_scan #(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIV     = 100000,
    parameter int BLANK_CYCLES = 16
) (
    input logic               clk,
    input logic               rst_n,
    hex_display_scan_if.slave bus
);
    localparam int PW = $clog2(SCAN_DIV);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int VW = 4 * NUM_DIGITS;

    logic [PW-1:0]         presc_q, presc_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic                  slot_end, wrap;
    logic [VW-1:0]         pend_val_q, shad_val_q;
    logic [NUM_DIGITS-1:0] pend_dp_q, pend_en_q;
    logic [NUM_DIGITS-1:0] shad_dp_q, shad_en_q;
    logic                  busy_q, tick_q;
    logic [NUM_DIGITS-1:0] anode_q, anode_d;
    logic [7:0]            cath_q, cath_d;
    logic [NUM_DIGITS-1:0] dark;
    logic [3:0]            nib;

    function automatic logic [7:0] glyph(input logic [3:0] n);
        logic [7:0] g;
        case (n)
            4'h0: g = 8'hC0;
            4'h1: g = 8'hF9;
            4'h2: g = 8'hA4;
            4'h3: g = 8'hB0;
            4'h4: g = 8'h99;
            4'h5: g = 8'h92;
            4'h6: g = 8'h82;
            4'h7: g = 8'hF8;
            4'h8: g = 8'h80;
            4'h9: g = 8'h90;
            4'hA: g = 8'h88;
            4'hB: g = 8'h83;
            4'hC: g = 8'hA7;
            4'hD: g = 8'hA1;
            4'hE: g = 8'h86;
            default: g = 8'h8E;
        endcase
        return g;
    endfunction

    assign slot_end = (presc_q == PW'(SCAN_DIV - 1));
    assign wrap     = slot_end && (idx_q == IW'(NUM_DIGITS - 1));

    // Next prescaler and digit index; index wraps at the last digit.
    always_comb begin
        presc_d = slot_end ? '0 : presc_q + PW'(1);
        idx_d   = idx_q;
        if (slot_end) begin
            idx_d = (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + IW'(1);
        end
    end

    // Scan position state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
            idx_q   <= '0;
        end else begin
            presc_q <= presc_d;
            idx_q   <= idx_d;
        end
    end

    // Capture path: pending buffer, promoted to shadow only at frame wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_val_q <= '0;
            pend_dp_q  <= '0;
            pend_en_q  <= '0;
            shad_val_q <= '0;
            shad_dp_q  <= '0;
            shad_en_q  <= '0;
            busy_q     <= 1'b0;
        end else if (wrap) begin
            busy_q <= 1'b0;
            if (bus.load) begin
                shad_val_q <= bus.value;
                shad_dp_q  <= bus.dp;
                shad_en_q  <= bus.digit_en;
            end else if (busy_q) begin
                shad_val_q <= pend_val_q;
                shad_dp_q  <= pend_dp_q;
                shad_en_q  <= pend_en_q;
            end
        end else if (bus.load) begin
            pend_val_q <= bus.value;
            pend_dp_q  <= bus.dp;
            pend_en_q  <= bus.digit_en;
            busy_q     <= 1'b1;
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic seen;

    // Dark mask for zero digits above the highest nonzero enabled digit.
    always_comb begin
        dark = '0;
        seen = 1'b0;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            if (shad_en_q[i] && shad_val_q[4*i +: 4] != 4'h0) begin
                seen = 1'b1;
            end
            dark[i] = !seen && (shad_val_q[4*i +: 4] == 4'h0) && !shad_dp_q[i];
        end
    end
`else
    assign dark = '0;
`endif

    assign nib = shad_val_q[{idx_q, 2'b00} +: 4];

    // Pin pattern for the current slot: dead time, disabled or lit digit.
    always_comb begin
        anode_d = '1;
        cath_d  = 8'hFF;
        if (presc_q >= PW'(BLANK_CYCLES) && shad_en_q[idx_q] && !dark[idx_q]) begin
            anode_d[idx_q] = 1'b0;
            cath_d         = glyph(nib);
            if (shad_dp_q[idx_q]) begin
                cath_d[7] = 1'b0;
            end
        end
    end

    // Registered pin outputs and frame pulse, dark while in reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            anode_q <= '1;
            cath_q  <= 8'hFF;
            tick_q  <= 1'b0;
        end else begin
            anode_q <= anode_d;
            cath_q  <= cath_d;
            tick_q  <= wrap;
        end
    end

    assign bus.busy       = busy_q;
    assign bus.frame_tick = tick_q;
    assign bus.anode      = anode_q;
    assign bus.cathode    = cath_q;
endmodule

// File: tb/tb_hex_display_scan.sv
// Bench for hex_display_scan: 4 digits, 8-cycle slots, 2 dead cycles.
// Behavioural slot/frame model checked every cycle plus directed literals.
module tb_hex_display_scan;
    localparam int ND = 4;
    localparam int SD = 8;
    localparam int BC = 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    hex_display_scan_if #(.NUM_DIGITS(ND)) bus ();

    hex_display_scan #(
        .NUM_DIGITS  (ND),
        .SCAN_DIV    (SD),
        .BLANK_CYCLES(BC)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    int checks = 0;
    int failures = 0;
    int ccount = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0]  GLY [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                              8'h80, 8'h90, 8'h88, 8'h83, 8'hA7, 8'hA1, 8'h86, 8'h8E};
    int          cyc;
    int          m_ph, m_dg;
    bit          m_wr, m_busy, e_tick;
    logic [15:0] sh_v, pd_v;
    logic [3:0]  sh_dp, sh_en, pd_dp, pd_en;
    logic [3:0]  e_an;
    logic [7:0]  e_ca;

    function automatic logic [3:0] digit_of(input logic [15:0] v, input int d);
        return 4'((v >> (4 * d)) & 16'hF);
    endfunction

    function automatic bit lz_dark(input int d);
        bit r;
        r = 0;
`ifdef LEADING_ZERO_BLANK_EN
        if (d > 0 && digit_of(sh_v, d) == 0 && !sh_dp[d]) begin
            r = 1;
            for (int j = d + 1; j < ND; j++)
                if (sh_en[j] && digit_of(sh_v, j) != 0) r = 0;
        end
`else
        if (d < 0) r = 1;
`endif
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc = 0; m_busy = 0; e_tick = 0;
            sh_v = 0; sh_dp = 0; sh_en = 0;
            pd_v = 0; pd_dp = 0; pd_en = 0;
            e_an = 4'hF; e_ca = 8'hFF;
        end else begin
            m_ph = cyc % SD;
            m_dg = (cyc / SD) % ND;
            m_wr = (m_ph == SD - 1) && (m_dg == ND - 1);
            e_an = 4'hF;
            e_ca = 8'hFF;
            if (m_ph >= BC && sh_en[m_dg] && !lz_dark(m_dg)) begin
                e_an = ~(4'b0001 << m_dg);
                e_ca = GLY[digit_of(sh_v, m_dg)];
                if (sh_dp[m_dg]) e_ca = e_ca & 8'h7F;
            end
            e_tick = m_wr;
            if (m_wr) begin
                if (bus.load) begin
                    sh_v = bus.value; sh_dp = bus.dp; sh_en = bus.digit_en;
                end else if (m_busy) begin
                    sh_v = pd_v; sh_dp = pd_dp; sh_en = pd_en;
                end
                m_busy = 0;
            end else if (bus.load) begin
                pd_v = bus.value; pd_dp = bus.dp; pd_en = bus.digit_en;
                m_busy = 1;
            end
            cyc++;
        end
    end

    always @(negedge clk) ccount++;

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        #2;
        chk("anode", {28'd0, bus.anode}, {28'd0, e_an});
        chk("cathode", {24'd0, bus.cathode}, {24'd0, e_ca});
        chk("busy", {31'd0, bus.busy}, {31'd0, m_busy});
        chk("frame_tick", {31'd0, bus.frame_tick}, {31'd0, e_tick});
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(negedge clk);
        #2;
    endtask

    task automatic wait_tick();
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (bus.frame_tick !== 1'b1 && n < 100);
        chk("tick_seen", {31'd0, bus.frame_tick}, 32'd1);
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic [3:0] e);
        bus.value = v; bus.dp = d; bus.digit_en = e; bus.load = 1'b1;
        step();
        bus.load = 1'b0;
    endtask

    // Call on a frame_tick cycle; checks dead time and first lit cycle per digit.
    task automatic check_frame(input string nm, input logic [15:0] an, input logic [31:0] ca);
        int k;
        k = 0;
        for (int d = 0; d < ND; d++) begin
            while (k < 8 * d + 2) begin step(); k++; end
            chk({nm, "_dead_an"}, {28'd0, bus.anode}, 32'hF);
            chk({nm, "_dead_ca"}, {24'd0, bus.cathode}, 32'hFF);
            step(); k++;
            chk({nm, "_an"}, {28'd0, bus.anode}, {28'd0, an[4*d +: 4]});
            chk({nm, "_ca"}, {24'd0, bus.cathode}, {24'd0, ca[8*d +: 8]});
        end
    endtask

    int r0, t0;

    initial begin
        rst_n = 1'b0;
        bus.value = '0; bus.dp = '0; bus.digit_en = '0; bus.load = 1'b0;
        repeat (3) step();
        chk("rst_anode", {28'd0, bus.anode}, 32'hF);
        chk("rst_cathode", {24'd0, bus.cathode}, 32'hFF);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_tick", {31'd0, bus.frame_tick}, 32'd0);
        #1 rst_n = 1'b1;
        r0 = ccount;

        // 1: idle frames stay dark, tick every 32 clocks
        wait_tick();
        chk("first_tick", ccount - r0, 32'd32);
        for (int f = 0; f < 2; f++) begin
            t0 = ccount;
            wait_tick();
            chk("tick_period", ccount - t0, 32'd32);
        end
        repeat (12) step();
        chk("idle_anode", {28'd0, bus.anode}, 32'hF);

        // 2: 12AF shown from the next frame
        wait_tick();
        do_load(16'h12AF, 4'h0, 4'hF);
        chk("t2_busy", {31'd0, bus.busy}, 32'd1);
        wait_tick();
        chk("t2_busy_clr", {31'd0, bus.busy}, 32'd0);
        check_frame("t2", 16'h7BDE, {8'hF9, 8'hA4, 8'h88, 8'h8E});

        // 3: back-to-back loads, last wins
        wait_tick();
        do_load(16'h0000, 4'h0, 4'hF);
        do_load(16'h3333, 4'h0, 4'hF);
        chk("t3_busy", {31'd0, bus.busy}, 32'd1);
        wait_tick();
        chk("t3_busy_clr", {31'd0, bus.busy}, 32'd0);
        check_frame("t3", 16'h7BDE, {8'hB0, 8'hB0, 8'hB0, 8'hB0});

        // 4: load in the wrap cycle bypasses to the shadow
        wait_tick();
        repeat (31) step();
        do_load(16'h8888, 4'h0, 4'hF);
        chk("t4_tick", {31'd0, bus.frame_tick}, 32'd1);
        chk("t4_busy", {31'd0, bus.busy}, 32'd0);
        check_frame("t4", 16'h7BDE, {8'h80, 8'h80, 8'h80, 8'h80});

        // 5: disabled digit and decimal points
        wait_tick();
        do_load(16'h5555, 4'b0100, 4'b1011);
        wait_tick();
        check_frame("t5a", 16'h7FDE, {8'h92, 8'hFF, 8'h92, 8'h92});
        wait_tick();
        do_load(16'h5555, 4'b0110, 4'b1011);
        wait_tick();
        check_frame("t5b", 16'h7FDE, {8'h92, 8'hFF, 8'h12, 8'h92});

        // 6: leading zeros
        wait_tick();
        do_load(16'h0070, 4'h0, 4'hF);
        wait_tick();
`ifdef LEADING_ZERO_BLANK_EN
        check_frame("t6", 16'hFFDE, {8'hFF, 8'hFF, 8'hF8, 8'hC0});
`else
        check_frame("t6", 16'h7BDE, {8'hC0, 8'hC0, 8'hF8, 8'hC0});
`endif

        // async reset mid-slot
        wait_tick();
        do_load(16'h4321, 4'h0, 4'hF);
        repeat (4) step();
        chk("pre_rst_an", {28'd0, bus.anode}, 32'hE);
        chk("pre_rst_ca", {24'd0, bus.cathode}, 32'hC0);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_mid_an", {28'd0, bus.anode}, 32'hF);
        chk("rst_mid_ca", {24'd0, bus.cathode}, 32'hFF);
        chk("rst_mid_busy", {31'd0, bus.busy}, 32'd0);
        repeat (2) step();
        #1 rst_n = 1'b1;
        r0 = ccount;
        wait_tick();
        chk("post_rst_tick", ccount - r0, 32'd32);
        repeat (10) step();
        chk("post_rst_dark", {28'd0, bus.anode}, 32'hF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
